// File: rtl/mem_sram_responder_if.sv
// Client read port and asynchronous SRAM pins of the SRAM read responder.
// The slave modport is the responder's view; the master modport is the client plus SRAM side.
interface mem_sram_responder_if;
  logic        readReq;
  logic [15:0] addr;
  logic        busy;
  logic [15:0] data;
  logic        dataReady;
  logic [15:0] sram_addr;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic [15:0] sram_dq;

  modport slave (
    input  readReq, addr, sram_dq,
    output busy, data, dataReady, sram_addr, sram_ce_n, sram_oe_n
  );

  modport master (
    output readReq, addr, sram_dq,
    input  busy, data, dataReady, sram_addr, sram_ce_n, sram_oe_n
  );
endinterface

// File: rtl/mem_sram_responder.sv
// Queues up to two client reads and plays them out in order on an asynchronous SRAM,
// sampling the data bus after WAIT_STATES extra cycles and pulsing dataReady once per read.
module mem_sram_responder #(
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_sram_responder_if.slave   bus
);

  typedef enum logic {IDLE, ACCESS} state_e;

  localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

  state_e      state_q, state_d;
  logic [3:0]  waitCnt_q, waitCnt_d;
  logic [1:0]  count_q, count_d;
  logic [15:0] fifo_q [2];
  logic [15:0] fifo_d [2];
  logic [15:0] sramAddr_q, sramAddr_d;
  logic        ceN_q, ceN_d;
  logic        oeN_q, oeN_d;
  logic [15:0] data_q, data_d;
  logic        dataReady_q, dataReady_d;
  logic        push;
  logic        pop;

  assign push = bus.readReq && (count_q != 2'd2);

  // Pop decisions look only at the registered count, so an entry pushed this
  // edge can never be issued before the following edge.
  always_comb begin
    state_d     = state_q;
    waitCnt_d   = waitCnt_q;
    sramAddr_d  = sramAddr_q;
    ceN_d       = ceN_q;
    oeN_d       = oeN_q;
    data_d      = data_q;
    dataReady_d = 1'b0;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != 2'd0) begin
          pop        = 1'b1;
          sramAddr_d = fifo_q[0];
          ceN_d      = 1'b0;
          oeN_d      = 1'b0;
          waitCnt_d  = WaitLoad;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (waitCnt_q != 4'd0) begin
          waitCnt_d = waitCnt_q - 4'd1;
        end else begin
          data_d      = bus.sram_dq;
          dataReady_d = 1'b1;
          if (count_q != 2'd0) begin
            pop        = 1'b1;
            sramAddr_d = fifo_q[0];
            waitCnt_d  = WaitLoad;
          end else begin
            ceN_d   = 1'b1;
            oeN_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift-register FIFO: pop moves entry 1 to the head, push fills the first free slot.
  always_comb begin
    fifo_d  = fifo_q;
    count_d = count_q;
    if (pop) begin
      fifo_d[0] = fifo_q[1];
      count_d   = count_q - 2'd1;
    end
    if (push) begin
      if (count_d == 2'd0) begin
        fifo_d[0] = bus.addr;
      end else begin
        fifo_d[1] = bus.addr;
      end
      count_d = count_d + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      waitCnt_q   <= 4'd0;
      count_q     <= 2'd0;
      fifo_q[0]   <= 16'h0;
      fifo_q[1]   <= 16'h0;
      sramAddr_q  <= 16'h0;
      ceN_q       <= 1'b1;
      oeN_q       <= 1'b1;
      data_q      <= 16'h0;
      dataReady_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      waitCnt_q   <= waitCnt_d;
      count_q     <= count_d;
      fifo_q      <= fifo_d;
      sramAddr_q  <= sramAddr_d;
      ceN_q       <= ceN_d;
      oeN_q       <= oeN_d;
      data_q      <= data_d;
      dataReady_q <= dataReady_d;
    end
  end

  assign bus.busy      = (count_q == 2'd2);
  assign bus.data      = data_q;
  assign bus.dataReady = dataReady_q;
  assign bus.sram_addr = sramAddr_q;
  assign bus.sram_ce_n = ceN_q;
  assign bus.sram_oe_n = oeN_q;

endmodule

// File: tb/tb_mem_sram_responder.sv
// Runs two responders (WAIT_STATES 2 and 0) off shared client stimulus and checks both
// against a transaction-timing model every cycle, plus directed literal expectations.
module tb_mem_sram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        readReq = 1'b0;
  logic [15:0] addr = 16'h0;
  logic        capReq = 1'b0;
  logic [15:0] capAddr = 16'h0;
  logic        capRst = 1'b1;
  int          compared = 0;
  int          mismatched = 0;

  mem_sram_responder_if busA ();
  mem_sram_responder_if busB ();

  mem_sram_responder #(.WAIT_STATES(2)) dutA (.clk(clk), .rst(rst), .bus(busA));
  mem_sram_responder #(.WAIT_STATES(0)) dutB (.clk(clk), .rst(rst), .bus(busB));

  assign busA.readReq = readReq;
  assign busA.addr    = addr;
  assign busB.readReq = readReq;
  assign busB.addr    = addr;
  assign busA.sram_dq = (!busA.sram_ce_n && !busA.sram_oe_n) ? ~busA.sram_addr : 16'hxxxx;
  assign busB.sram_dq = (!busB.sram_ce_n && !busB.sram_oe_n) ? ~busB.sram_addr : 16'hxxxx;

  logic [15:0] actBusy  [2];
  logic [15:0] actData  [2];
  logic [15:0] actReady [2];
  logic [15:0] actSAddr [2];
  logic [15:0] actCe    [2];
  logic [15:0] actOe    [2];

  assign actBusy[0]  = 16'(busA.busy);
  assign actBusy[1]  = 16'(busB.busy);
  assign actData[0]  = busA.data;
  assign actData[1]  = busB.data;
  assign actReady[0] = 16'(busA.dataReady);
  assign actReady[1] = 16'(busB.dataReady);
  assign actSAddr[0] = busA.sram_addr;
  assign actSAddr[1] = busB.sram_addr;
  assign actCe[0]    = 16'(busA.sram_ce_n);
  assign actCe[1]    = 16'(busB.sram_ce_n);
  assign actOe[0]    = 16'(busA.sram_oe_n);
  assign actOe[1]    = 16'(busB.sram_oe_n);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    capReq  <= readReq;
    capAddr <= addr;
    capRst  <= rst;
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [15:0] a);
    readReq = req;
    addr    = a;
    @(posedge clk);
    #2;
  endtask

  // Transaction model: a read started at step s is sampled at step s+1+W.
  for (genvar g = 0; g < 2; g++) begin : gModel
    localparam int W = (g == 0) ? 2 : 0;
    logic [15:0] q [$];
    logic        inFlight = 1'b0;
    logic [15:0] curAddr = 16'h0;
    logic [15:0] expData = 16'h0;
    logic        expReady = 1'b0;
    int          step = 0;
    int          sampleStep = 0;
    int          oldSize;
    bit          startNext;

    always @(negedge clk) begin
      step++;
      if (capRst || rst) begin
        q.delete();
        inFlight = 1'b0;
        curAddr  = 16'h0;
        expData  = 16'h0;
        expReady = 1'b0;
      end else begin
        oldSize   = q.size();
        expReady  = 1'b0;
        startNext = 1'b0;
        if (inFlight && step == sampleStep) begin
          expData  = ~curAddr;
          expReady = 1'b1;
          if (oldSize > 0) startNext = 1'b1;
          else inFlight = 1'b0;
        end else if (!inFlight && oldSize > 0) begin
          startNext = 1'b1;
        end
        if (startNext) begin
          curAddr    = q.pop_front();
          sampleStep = step + 1 + W;
          inFlight   = 1'b1;
        end
        if (capReq && oldSize < 2) q.push_back(capAddr);
      end
      checkOutput($sformatf("W%0d busy", W), actBusy[g], 16'(q.size() == 2));
      checkOutput($sformatf("W%0d data", W), actData[g], expData);
      checkOutput($sformatf("W%0d dataReady", W), actReady[g], 16'(expReady));
      checkOutput($sformatf("W%0d sram_addr", W), actSAddr[g], curAddr);
      checkOutput($sformatf("W%0d ce_n", W), actCe[g], 16'(!inFlight));
      checkOutput($sformatf("W%0d oe_n", W), actOe[g], 16'(!inFlight));
    end
  end

  initial begin
    int pulses;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst busy", 16'(busA.busy), 16'h0);
    checkOutput("rst data", busA.data, 16'h0);
    checkOutput("rst dataReady", 16'(busA.dataReady), 16'h0);
    checkOutput("rst sram_addr", busA.sram_addr, 16'h0);
    checkOutput("rst ce_n", 16'(busA.sram_ce_n), 16'h1);
    checkOutput("rst oe_n", 16'(busA.sram_oe_n), 16'h1);
    rst = 1'b0;

    // Single read with two wait states.
    applyStimulus(1'b1, 16'h1234);
    checkOutput("single no bypass ce_n", 16'(busA.sram_ce_n), 16'h1);
    applyStimulus(1'b0, 16'h0);
    checkOutput("single drive addr", busA.sram_addr, 16'h1234);
    checkOutput("single drive ce_n", 16'(busA.sram_ce_n), 16'h0);
    checkOutput("single drive oe_n", 16'(busA.sram_oe_n), 16'h0);
    applyStimulus(1'b0, 16'h0);
    applyStimulus(1'b0, 16'h0);
    checkOutput("single early ready", 16'(busA.dataReady), 16'h0);
    applyStimulus(1'b0, 16'h0);
    checkOutput("single data", busA.data, 16'hEDCB);
    checkOutput("single ready", 16'(busA.dataReady), 16'h1);
    checkOutput("single release ce_n", 16'(busA.sram_ce_n), 16'h1);
    applyStimulus(1'b0, 16'h0);
    checkOutput("single ready one cycle", 16'(busA.dataReady), 16'h0);
    checkOutput("single data held", busA.data, 16'hEDCB);
    repeat (3) applyStimulus(1'b0, 16'h0);

    // Queue fill, same-edge push/pop, dropped request while busy.
    applyStimulus(1'b1, 16'ha222);
    applyStimulus(1'b1, 16'ha333);
    checkOutput("collision busy", 16'(busA.busy), 16'h0);
    checkOutput("collision head issued", busA.sram_addr, 16'ha222);
    applyStimulus(1'b1, 16'ha444);
    checkOutput("queue full busy", 16'(busA.busy), 16'h1);
    applyStimulus(1'b1, 16'ha555);
    checkOutput("queue full busy held", 16'(busA.busy), 16'h1);
    applyStimulus(1'b0, 16'h0);
    checkOutput("queue first data", busA.data, 16'h5DDD);
    checkOutput("queue first ready", 16'(busA.dataReady), 16'h1);
    applyStimulus(1'b0, 16'h0);
    applyStimulus(1'b0, 16'h0);
    checkOutput("queue gap ready", 16'(busA.dataReady), 16'h0);
    applyStimulus(1'b0, 16'h0);
    checkOutput("queue second data", busA.data, 16'h5CCC);
    checkOutput("queue second ready", 16'(busA.dataReady), 16'h1);
    repeat (3) applyStimulus(1'b0, 16'h0);
    checkOutput("queue third data", busA.data, 16'h5BBB);
    repeat (4) applyStimulus(1'b0, 16'h0);

    // Zero wait states, back-to-back reads.
    applyStimulus(1'b1, 16'h0f0f);
    applyStimulus(1'b1, 16'h1111);
    checkOutput("b2b drive ce_n", 16'(busB.sram_ce_n), 16'h0);
    applyStimulus(1'b0, 16'h0);
    checkOutput("b2b first data", busB.data, 16'hF0F0);
    checkOutput("b2b first ready", 16'(busB.dataReady), 16'h1);
    checkOutput("b2b ce_n held", 16'(busB.sram_ce_n), 16'h0);
    applyStimulus(1'b0, 16'h0);
    checkOutput("b2b second data", busB.data, 16'hEEEE);
    checkOutput("b2b second ready", 16'(busB.dataReady), 16'h1);
    repeat (8) applyStimulus(1'b0, 16'h0);

    // Reset one cycle after the SRAM drive, with one entry queued.
    applyStimulus(1'b1, 16'hb000);
    applyStimulus(1'b1, 16'hb111);
    applyStimulus(1'b0, 16'h0);
    rst = 1'b1;
    #1;
    checkOutput("mid rst ce_n", 16'(busA.sram_ce_n), 16'h1);
    checkOutput("mid rst oe_n", 16'(busA.sram_oe_n), 16'h1);
    checkOutput("mid rst sram_addr", busA.sram_addr, 16'h0);
    checkOutput("mid rst data", busA.data, 16'h0);
    checkOutput("mid rst busy", 16'(busA.busy), 16'h0);
    #1;
    repeat (2) applyStimulus(1'b0, 16'h0);
    rst = 1'b0;
    pulses = 0;
    repeat (8) begin
      applyStimulus(1'b0, 16'h0);
      if (busA.dataReady || busB.dataReady) pulses++;
    end
    checkOutput("no ready after rst", 16'(pulses), 16'h0);

    // Request on the very first edge after reset release.
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0);
    rst = 1'b0;
    applyStimulus(1'b1, 16'hc0de);
    applyStimulus(1'b0, 16'h0);
    checkOutput("first edge accept addr", busA.sram_addr, 16'hc0de);
    checkOutput("first edge accept ce_n", 16'(busA.sram_ce_n), 16'h0);
    repeat (6) applyStimulus(1'b0, 16'h0);

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      applyStimulus($urandom_range(0, 2) != 0, 16'($urandom));
    end
    rst = 1'b0;
    repeat (30) applyStimulus(1'b0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
